// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: NOP encoding, opcodes,
// instruction field widths and the next-PC source selector.
package pc_fetch_unit_pkg;

  localparam logic [31:0] CPU_NOP_INST = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam int JIDX_W = 26;
  localparam int IMM_W  = 16;

  typedef enum logic [1:0] {
    SEL_JUMP,
    SEL_BRANCH,
    SEL_STALL,
    SEL_SEQ
  } pc_sel_e;

  // Sign-extended branch immediate scaled to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC selection: jump over branch over stall over
// sequential fetch.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0]       pc_i,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [JIDX_W-1:0] jump_index_i,
  input  logic              branch_i,
  input  logic [IMM_W-1:0]  branch_imm_i,
  input  logic [31:0]       base_pc4_i,
  output logic [31:0]       pc4_o,
  output logic [31:0]       jtarget_o,
  output logic [31:0]       btarget_o,
  output logic [31:0]       next_pc_o,
  output pc_sel_e           sel_o
);

  assign pc4_o     = pc_i + 32'd4;
  assign jtarget_o = {base_pc4_i[31:28], jump_index_i, 2'b00};
  assign btarget_o = base_pc4_i + branch_offset(branch_imm_i);

  always_comb begin
    sel_o     = SEL_SEQ;
    next_pc_o = pc4_o;
    if (jump_i) begin
      sel_o     = SEL_JUMP;
      next_pc_o = jtarget_o;
    end else if (branch_i) begin
      sel_o     = SEL_BRANCH;
      next_pc_o = btarget_o;
    end else if (stall_i) begin
      sel_o     = SEL_STALL;
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: program counter, IF/ID pipeline register,
// fetch counter and sticky out-of-range flag.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 32,
  parameter logic [31:0] NOP_INST  = CPU_NOP_INST
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic [31:0]       Addr,
  input  logic [31:0]       Inst,
  input  logic              Stall,
  input  logic              Jump,
  input  logic [JIDX_W-1:0] Jump_Index,
  input  logic              Branch,
  input  logic [IMM_W-1:0]  Branch_Imm,
  input  logic [31:0]       Base_Pc4,
  output logic [31:0]       IfId_Inst,
  output logic [31:0]       IfId_Pc4,
  output logic              IfId_Valid,
  output logic [31:0]       Fetch_Count,
  output logic              Out_Of_Range
);

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        oor_q, oor_d;

  logic [31:0] pc4;
  logic [31:0] jtarget;
  logic [31:0] btarget;
  logic [31:0] next_pc;
  pc_sel_e     sel;
  logic        addr_oor;

  pc_next_sel u_next_sel (
    .pc_i         (addr_q),
    .stall_i      (Stall),
    .jump_i       (Jump),
    .jump_index_i (Jump_Index),
    .branch_i     (Branch),
    .branch_imm_i (Branch_Imm),
    .base_pc4_i   (Base_Pc4),
    .pc4_o        (pc4),
    .jtarget_o    (jtarget),
    .btarget_o    (btarget),
    .next_pc_o    (next_pc),
    .sel_o        (sel)
  );

  assign addr_oor = ({2'b00, addr_q[31:2]} >= ROM_LIMIT);

  always_comb begin
    addr_d  = next_pc;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    oor_d   = oor_q;
    unique case (sel)
      SEL_JUMP, SEL_BRANCH: begin
        // Redirect kills the instruction fetched down the wrong path.
        inst_d  = NOP_INST;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end
      SEL_STALL: begin
      end
      SEL_SEQ: begin
        inst_d  = Inst;
        pc4_d   = pc4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
        if (addr_oor) oor_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_q  <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      count_q <= 32'h0;
      oor_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
      oor_q   <= oor_d;
    end
  end

  assign Addr         = addr_q;
  assign IfId_Inst    = inst_q;
  assign IfId_Pc4     = pc4_q;
  assign IfId_Valid   = valid_q;
  assign Fetch_Count  = count_q;
  assign Out_Of_Range = oor_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; expected states go into a scoreboard
// queue and a monitor compares them one cycle later.
module tb_pc_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic [31:0] Addr;
  logic [31:0] Inst;
  logic        Stall;
  logic        Jump;
  logic [25:0] Jump_Index;
  logic        Branch;
  logic [15:0] Branch_Imm;
  logic [31:0] Base_Pc4;
  logic [31:0] IfId_Inst;
  logic [31:0] IfId_Pc4;
  logic        IfId_Valid;
  logic [31:0] Fetch_Count;
  logic        Out_Of_Range;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
    logic        oor;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .ROM_WORDS (32),
    .NOP_INST  (32'h0000_0000)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Addr         (Addr),
    .Inst         (Inst),
    .Stall        (Stall),
    .Jump         (Jump),
    .Jump_Index   (Jump_Index),
    .Branch       (Branch),
    .Branch_Imm   (Branch_Imm),
    .Base_Pc4     (Base_Pc4),
    .IfId_Inst    (IfId_Inst),
    .IfId_Pc4     (IfId_Pc4),
    .IfId_Valid   (IfId_Valid),
    .Fetch_Count  (Fetch_Count),
    .Out_Of_Range (Out_Of_Range)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Program ROM: word 0 is ori $1,$0,10; the rest are tagged with their index.
  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    if (idx == 30'd0) return 32'h3401_000A;
    return 32'hA500_0000 ^ {2'b00, idx};
  endfunction

  always_comb Inst = rom_word(Addr[31:2]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".Addr"},         Addr,                 e.addr);
    chk({tag, ".IfId_Inst"},    IfId_Inst,            e.inst);
    chk({tag, ".IfId_Pc4"},     IfId_Pc4,             e.pc4);
    chk({tag, ".IfId_Valid"},   {31'b0, IfId_Valid},  {31'b0, e.valid});
    chk({tag, ".Fetch_Count"},  Fetch_Count,          e.cnt);
    chk({tag, ".Out_Of_Range"}, {31'b0, Out_Of_Range}, {31'b0, e.oor});
    $display("state %s Addr=%h IfId_Inst=%h IfId_Pc4=%h V=%0b Cnt=%0d OOR=%0b",
             tag, Addr, IfId_Inst, IfId_Pc4, IfId_Valid, Fetch_Count, Out_Of_Range);
  endtask

  // Monitor: one expected state per clock edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk_state("edge", e);
      end
    end
  end

  // Drive one cycle's decode inputs, queue the state expected after the edge.
  task automatic step(input logic j, input logic [25:0] jidx, input logic b,
                      input logic [15:0] bimm, input logic [31:0] base, input logic st,
                      input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                      input logic ev, input logic [31:0] ec, input logic eo);
    exp_t e;
    Jump = j; Jump_Index = jidx; Branch = b; Branch_Imm = bimm;
    Base_Pc4 = base; Stall = st;
    e.addr = ea; e.inst = ei; e.pc4 = ep; e.valid = ev; e.cnt = ec; e.oor = eo;
    sb_q.push_back(e);
    @(posedge Clk);
    #2;
  endtask

  task automatic seq(input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] ec, input logic eo);
    step(1'b0, 26'h0, 1'b0, 16'h0, 32'h0, 1'b0, ea, ei, ep, 1'b1, ec, eo);
  endtask

  task automatic check_reset_state(input string tag);
    exp_t e;
    e.addr = 32'h0; e.inst = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0; e.cnt = 32'h0; e.oor = 1'b0;
    chk_state(tag, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; Stall = 1'b0; Jump = 1'b0; Jump_Index = 26'h0;
    Branch = 1'b0; Branch_Imm = 16'h0; Base_Pc4 = 32'h0;
    repeat (2) @(posedge Clk);
    #2;
    check_reset_state("reset");
    Rst = 1'b0;

    // Sequential fetch from reset.
    seq(32'h04, 32'h3401_000A, 32'h04, 1, 1'b0);
    seq(32'h08, rom_word(30'd1), 32'h08, 2, 1'b0);
    seq(32'h0C, rom_word(30'd2), 32'h0C, 3, 1'b0);
    seq(32'h10, rom_word(30'd3), 32'h10, 4, 1'b0);

    // Three stalled cycles at Addr=0x10.
    for (int i = 0; i < 3; i++)
      step(1'b0, 26'h0, 1'b0, 16'h0, 32'h0, 1'b1, 32'h10, rom_word(30'd3), 32'h10, 1'b1, 4, 1'b0);

    // Branch with Stall: redirect wins.
    step(1'b0, 26'h0, 1'b1, 16'h0004, 32'h14, 1'b1, 32'h24, 32'h0, 32'h0, 1'b0, 4, 1'b0);
    seq(32'h28, rom_word(30'd9), 32'h28, 5, 1'b0);

    // Jump to 0x30, target in IF/ID one edge later.
    step(1'b1, 26'h000000C, 1'b0, 16'h0, 32'h20, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 5, 1'b0);
    seq(32'h34, rom_word(30'd12), 32'h34, 6, 1'b0);

    // Forward and backward branches.
    step(1'b0, 26'h0, 1'b1, 16'h0004, 32'h38, 1'b0, 32'h48, 32'h0, 32'h0, 1'b0, 6, 1'b0);
    seq(32'h4C, rom_word(30'd18), 32'h4C, 7, 1'b0);
    step(1'b0, 26'h0, 1'b1, 16'hFFFA, 32'h40, 1'b0, 32'h28, 32'h0, 32'h0, 1'b0, 7, 1'b0);
    seq(32'h2C, rom_word(30'd10), 32'h2C, 8, 1'b0);

    // Jump and Branch together: jump target 0x14 wins over branch 0x40.
    step(1'b1, 26'h0000005, 1'b1, 16'h0004, 32'h30, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 8, 1'b0);
    seq(32'h18, rom_word(30'd5), 32'h18, 9, 1'b0);

    // Async reset pulse mid-cycle while a jump is being presented.
    Jump = 1'b1; Jump_Index = 26'h0000020; Base_Pc4 = 32'h20;
    #3;
    Rst = 1'b1;
    #1;
    check_reset_state("midreset");
    Jump = 1'b0;
    @(posedge Clk);
    #2;
    Rst = 1'b0;

    // Free run across the ROM boundary at word 32 (Addr 0x80).
    for (int k = 1; k <= 35; k++)
      seq(32'(4 * k), rom_word(30'(k - 1)), 32'(4 * k), 32'(k), (k >= 33) ? 1'b1 : 1'b0);

    // Jump keeps upper PC bits from Base_Pc4; flag stays set.
    step(1'b1, 26'h0000003, 1'b0, 16'h0, 32'hF000_0000, 1'b0, 32'hF000_000C, 32'h0, 32'h0, 1'b0, 35, 1'b1);
    seq(32'hF000_0010, rom_word(30'h3C00_0003), 32'hF000_0010, 36, 1'b1);

    // Top of address space: PC+4 wraps to zero.
    step(1'b1, 26'h3FF_FFFF, 1'b0, 16'h0, 32'hF000_0000, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 36, 1'b1);
    seq(32'h0, rom_word(30'h3FFF_FFFF), 32'h0, 37, 1'b1);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge Clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'h0);

    // Only reset clears the sticky range flag.
    #3;
    Rst = 1'b1;
    #1;
    check_reset_state("final_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
